// File: rtl/down_count_sequencer.sv
// Sequences N 16-cycle rounds of an external 4-bit sync-set down counter, one TC strobe per round.
// Optional SEQ_ABORT_EN adds an ABORT input that cancels a running sequence.
module down_count_sequencer (
  input  logic       C,
  input  logic       CLR,
  input  logic       START,
  input  logic [3:0] ROUNDS,
  input  logic [3:0] Q_IN,
`ifdef SEQ_ABORT_EN
  input  logic       ABORT,
`endif
  output logic       S_OUT,
  output logic       BUSY,
  output logic       TC,
  output logic       DONE,
  output logic [3:0] ROUND_CNT
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t     state, state_nxt;
  logic [3:0] rounds_q, rounds_nxt;
  logic [3:0] rcnt_nxt, rcnt_inc;
  logic       zdone, zdone_nxt;
  logic       abort_req;

`ifdef SEQ_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif

  assign rcnt_inc = (ROUND_CNT == 4'hF) ? ROUND_CNT : ROUND_CNT + 4'd1;

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state     <= IDLE;
      rounds_q  <= 4'd0;
      ROUND_CNT <= 4'd0;
      zdone     <= 1'b0;
    end else begin
      state     <= state_nxt;
      rounds_q  <= rounds_nxt;
      ROUND_CNT <= rcnt_nxt;
      zdone     <= zdone_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rounds_nxt = rounds_q;
    rcnt_nxt   = ROUND_CNT;
    zdone_nxt  = 1'b0;
    S_OUT      = 1'b1;
    BUSY       = 1'b0;
    TC         = 1'b0;
    // a zero-round request completes without leaving IDLE
    DONE       = zdone;
    case (state)
      IDLE: begin
        if (START) begin
          rcnt_nxt = 4'd0;
          if (ROUNDS != 4'd0) begin
            rounds_nxt = ROUNDS;
            state_nxt  = RUN;
          end else begin
            zdone_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        S_OUT = 1'b0;
        BUSY  = 1'b1;
        TC    = (Q_IN == 4'd0);
        // abort takes priority over a completing TC on the same edge
        if (abort_req) begin
          state_nxt = IDLE;
        end else if (TC) begin
          rcnt_nxt = rcnt_inc;
          if (rcnt_inc == rounds_q) state_nxt = FINISH;
        end
      end
      FINISH: begin
        BUSY      = 1'b1;
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_down_count_sequencer.sv
// Scoreboard bench: expected TC/DONE events are queued at START, a negedge monitor compares them.
module tb_down_count_sequencer;

  logic       C = 1'b0;
  logic       CLR, START;
  logic [3:0] ROUNDS;
  logic       S_OUT, BUSY, TC, DONE;
  logic [3:0] ROUND_CNT;
  logic [3:0] q_cnt = 4'hF;
`ifdef SEQ_ABORT_EN
  logic       abort_in = 1'b0;
`endif

  down_count_sequencer dut (
    .C(C), .CLR(CLR), .START(START), .ROUNDS(ROUNDS), .Q_IN(q_cnt),
`ifdef SEQ_ABORT_EN
    .ABORT(abort_in),
`endif
    .S_OUT(S_OUT), .BUSY(BUSY), .TC(TC), .DONE(DONE), .ROUND_CNT(ROUND_CNT)
  );

  always #5 C = ~C;

  // downstream 4-bit down counter with synchronous set
  always @(posedge C) q_cnt <= S_OUT ? 4'hF : q_cnt - 4'd1;

  int edge_no = 0;
  always @(posedge C) edge_no <= edge_no + 1;

  typedef struct {
    bit is_done;
    int ev_edge;
    int rcnt;
  } ev_t;

  ev_t evq[$];
  localparam int BIG = 32'h3fff_ffff;
  int  mk = 0, mn = 0, mend = BIG;
  int  passed = 0, total = 0;
  bit  mon_en = 1'b0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
  endtask

  function automatic int exp_rcnt(int e);
    int ee, r;
    if (e < mk) return 0;
    ee = (e < mend) ? e : mend;
    r  = (ee - mk) / 16;
    return (r > mn) ? mn : r;
  endfunction

  function automatic bit exp_busy(int e);
    return mn > 0 && e >= mk && e <= mk + 16 * mn && e <= mend;
  endfunction

  function automatic bit exp_sout(int e);
    return !(mn > 0 && e >= mk && e < mk + 16 * mn && e <= mend);
  endfunction

  always @(negedge C) begin
    if (mon_en) begin
      int  e;
      ev_t ev;
      e = edge_no;
      chk("busy", int'(BUSY), int'(exp_busy(e)));
      chk("s_out", int'(S_OUT), int'(exp_sout(e)));
      chk("round_cnt", int'(ROUND_CNT), exp_rcnt(e));
      if (mn > 0 && mend == BIG && e == mk + 16 * mn + 1)
        chk("counter_reload", int'(q_cnt), 15);
      while (evq.size() > 0 && evq[0].ev_edge < e) begin
        ev = evq.pop_front();
        total++;
        $display("FAIL missed_event: got none, expected %s after edge %0d",
                 ev.is_done ? "DONE" : "TC", ev.ev_edge);
      end
      if (TC || DONE) begin
        if (evq.size() == 0 || evq[0].ev_edge != e) begin
          total++;
          $display("FAIL unexpected_event: got TC=%0b DONE=%0b after edge %0d, expected none",
                   TC, DONE, e);
        end else begin
          ev = evq.pop_front();
          chk("event_tc", int'(TC), int'(!ev.is_done));
          chk("event_done", int'(DONE), int'(ev.is_done));
          chk("event_round_cnt", int'(ROUND_CNT), ev.rcnt);
        end
      end
    end
  end

  task automatic start_seq(int n);
    @(negedge C);
    START  = 1'b1;
    ROUNDS = 4'(n);
    @(posedge C);
    #1;
    START = 1'b0;
    mk    = edge_no;
    mn    = n;
    mend  = BIG;
    for (int r = 1; r <= n; r++) evq.push_back('{1'b0, mk + 16 * r - 1, r - 1});
    evq.push_back('{1'b1, mk + 16 * n, n});
  endtask

  // keeps poking START/ROUNDS while busy; mode 1 = CLR, mode 2 = ABORT at cycle mk+at
  task automatic run_seq(int mode, int at);
    int e, idle_from;
    idle_from = (mn == 0) ? mk + 1 : mk + 16 * mn + 2;
    forever begin
      @(negedge C);
      e = edge_no;
      if (e + 1 >= idle_from) begin
        START = 1'b0;
        break;
      end
      START  = ($urandom_range(0, 3) == 0);
      ROUNDS = 4'($urandom_range(0, 15));
      if (mode == 1 && e == mk + at) begin
        START = 1'b0;
        #2 CLR = 1'b1;
        #1;
        chk("clr_busy", int'(BUSY), 0);
        chk("clr_s_out", int'(S_OUT), 1);
        chk("clr_done", int'(DONE), 0);
        chk("clr_tc", int'(TC), 0);
        chk("clr_round_cnt", int'(ROUND_CNT), 0);
        evq.delete();
        mk = 0; mn = 0; mend = BIG;
        @(negedge C);
        CLR = 1'b0;
        break;
      end
`ifdef SEQ_ABORT_EN
      if (mode == 2 && e == mk + at) begin
        START    = 1'b0;
        abort_in = 1'b1;
        mend     = e;
        while (evq.size() > 0 && evq[$].ev_edge > e) void'(evq.pop_back());
        @(negedge C);
        abort_in = 1'b0;
        break;
      end
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected bench to end");
    $fatal(1, "timeout");
  end

  initial begin
    int n, mode, at;
    CLR = 1'b1; START = 1'b0; ROUNDS = 4'd0;
    #3;
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_s_out", int'(S_OUT), 1);
    chk("reset_done", int'(DONE), 0);
    chk("reset_tc", int'(TC), 0);
    chk("reset_round_cnt", int'(ROUND_CNT), 0);
    repeat (2) @(negedge C);
    CLR    = 1'b0;
    mon_en = 1'b1;

    start_seq(1);  run_seq(0, 0);
    start_seq(3);  run_seq(0, 0);
    start_seq(0);  run_seq(0, 0);
    start_seq(2);  run_seq(1, 25);
    start_seq(15); run_seq(0, 0);
`ifdef SEQ_ABORT_EN
    start_seq(2);  run_seq(2, 15);
    start_seq(3);  run_seq(2, 20);
`endif
    for (int i = 0; i < 24; i++) begin
      n    = $urandom_range(0, 5);
      mode = 0;
      at   = 0;
      if (n > 0 && $urandom_range(0, 5) == 0) begin
        mode = 1;
        at   = $urandom_range(0, 16 * n);
      end
`ifdef SEQ_ABORT_EN
      else if (n > 0 && $urandom_range(0, 3) == 0) begin
        mode = 2;
        at   = $urandom_range(0, 16 * n - 1);
      end
`endif
      start_seq(n);
      run_seq(mode, at);
      repeat ($urandom_range(0, 3)) @(negedge C);
    end

    repeat (4) @(negedge C);
    #1;
    chk("leftover_events", evq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
